// File: rtl/pipe_arbiter.sv
// pipe_arbiter: two-requester arbiter feeding a free-running fixed-latency
// dot-product pipeline. A tag shift register tracks the owner of each op.
// Results are steered into per-requester response FIFOs. Credit gating keeps
// a FIFO slot reserved for every in-flight op.
// Optional feature: define PIPE_ARB_FIXED_PRIO_EN for fixed priority (r0 wins);
// default is round-robin.
module pipe_arbiter #(
  parameter int unsigned W     = 32,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a1,
  input  logic [W-1:0] r0_a2,
  input  logic [W-1:0] r0_b1,
  input  logic [W-1:0] r0_b2,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a1,
  input  logic [W-1:0] r1_a2,
  input  logic [W-1:0] r1_b1,
  input  logic [W-1:0] r1_b2,
  output logic [W-1:0] dp_a1,
  output logic [W-1:0] dp_a2,
  output logic [W-1:0] dp_b1,
  output logic [W-1:0] dp_b2,
  input  logic [W-1:0] dp_c,
  output logic         o0_valid,
  input  logic         o0_ready,
  output logic [W-1:0] o0_data,
  output logic         o1_valid,
  input  logic         o1_ready,
  output logic [W-1:0] o1_data,
  output logic         busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]   req_valid;
  logic [1:0]   out_ready;
  logic [1:0]   elig;
  logic [1:0]   grant;
  logic [1:0]   push;
  logic [1:0]   pop;
  logic [1:0]   nonempty;
  logic [W-1:0] head [2];
  logic [LAT:0] tag_vld_q;
  logic [LAT:0] tag_id_q;

  assign req_valid = {r1_valid, r0_valid};
  assign out_ready = {o1_ready, o0_ready};

`ifdef PIPE_ARB_FIXED_PRIO_EN
  // Fixed priority: r1 is served only when r0 cannot be
  always_comb begin
    grant    = '0;
    grant[0] = elig[0];
    grant[1] = elig[1] & ~elig[0];
  end
`else
  typedef enum logic {LAST_R0, LAST_R1} last_e;
  last_e last_q;

  // Round-robin: on contention grant the requester not served last
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = (last_q == LAST_R1) ? 2'b01 : 2'b10;
    end
  end

  // Last-grant pointer moves only on an actual transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_R1;
    end else if (grant[0]) begin
      last_q <= LAST_R0;
    end else if (grant[1]) begin
      last_q <= LAST_R1;
    end
  end
`endif

  // grant is already a transfer since ready == grant; masked while in reset
  assign r0_ready = grant[0] & rst_n;
  assign r1_ready = grant[1] & rst_n;

  // Issue stage: granted operands, or zeros on an idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a1 <= '0;
      dp_a2 <= '0;
      dp_b1 <= '0;
      dp_b2 <= '0;
    end else if (grant[0]) begin
      dp_a1 <= r0_a1;
      dp_a2 <= r0_a2;
      dp_b1 <= r0_b1;
      dp_b2 <= r0_b2;
    end else if (grant[1]) begin
      dp_a1 <= r1_a1;
      dp_a2 <= r1_a2;
      dp_b1 <= r1_b1;
      dp_b2 <= r1_b2;
    end else begin
      dp_a1 <= '0;
      dp_a2 <= '0;
      dp_b1 <= '0;
      dp_b2 <= '0;
    end
  end

  // Owner tags: stage 0 is the issue stage, stage LAT lines up with dp_c
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[LAT-1:0], |grant};
      tag_id_q  <= {tag_id_q[LAT-1:0], grant[1]};
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] occ_q;
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  mem_q [DEPTH];

    assign elig[g]     = req_valid[g] && (cnt_q < CW'(DEPTH));
    assign push[g]     = tag_vld_q[LAT] && (tag_id_q[LAT] == 1'(g));
    assign nonempty[g] = (occ_q != '0);
    assign pop[g]      = nonempty[g] && out_ready[g];
    assign head[g]     = nonempty[g] ? mem_q[rd_q] : '0;

    // Credits: in-flight tags plus stored entries; issue and pop cancel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (grant[g] && !pop[g]) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!grant[g] && pop[g]) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end

    // FIFO pointers and occupancy; a pop frees the head in the same edge as a push
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        occ_q <= '0;
      end else begin
        if (push[g]) wr_q <= wr_q + AW'(1);
        if (pop[g])  rd_q <= rd_q + AW'(1);
        if (push[g] && !pop[g]) begin
          occ_q <= occ_q + CW'(1);
        end else if (!push[g] && pop[g]) begin
          occ_q <= occ_q - CW'(1);
        end
      end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wr_q] <= dp_c;
    end
  end

  assign o0_valid = nonempty[0];
  assign o1_valid = nonempty[1];
  assign o0_data  = head[0];
  assign o1_data  = head[1];
  assign busy     = (|tag_vld_q) | (|nonempty);

endmodule

// File: doc/pipe_arbiter.md
# pipe_arbiter

Two-requester arbiter and scheduler for the free-running dot-product pipeline (C = A1*B1 + A2*B2, fixed latency, no enable, no stall). It accepts operand sets from two independent requesters over valid/ready handshakes and issues at most one set per cycle into the pipeline. It tracks each in-flight operation's owner in a tag shift register and steers every result into that owner's response FIFO. Credit gating ensures a result always has a FIFO slot, so the pipeline never needs back-pressure.

## Interface
Parameters:
- W, 32, operand/result width
- LAT, 2, cycles from dp_* operands presented to matching dp_c (≥1)
- DEPTH, 4, per-requester response FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rN_valid  in  1  requester N (N = 0, 1) operand set valid
- rN_ready  out  1  requester N accepted this cycle (combinational)
- rN_a1, rN_a2, rN_b1, rN_b2  in  W each  requester N operands
- dp_a1, dp_a2, dp_b1, dp_b2  out  W each  registered operands to the pipeline
- dp_c  in  W  pipeline result
- oN_valid  out  1  response N FIFO non-empty
- oN_ready  in  1  consumer N pops
- oN_data  out  W  head of response N FIFO
- busy  out  1  any tag in flight or any FIFO non-empty

## Operation
- Transfer on rN occurs when rN_valid & rN_ready at a rising edge.
- Credit: cnt[N] = in-flight tags owned by N + FIFO N occupancy. N is eligible iff rN_valid & (cnt[N] < DEPTH).
- Arbitration: round-robin with a last-grant pointer. If both requesters are eligible, grant the one not granted last. If one is eligible, grant it. The pointer updates only on an actual transfer.
- rN_ready = grant[N]. At most one is high per cycle. ready does not depend on the other requester's ready.
- On transfer: dp_* <= the granted operands, and tag[0] <= {valid=1, id=N}. With no transfer: dp_* <= 0, tag[0] <= invalid.
- Tag pipe: LAT+1 stages (registered issue stage plus LAT). The tag leaving the final stage is aligned with dp_c.
- Retire: if the final tag is valid, write dp_c into FIFO[id] at that edge.
- cnt[N] increments on transfer and decrements on an oN pop. Both in the same cycle leave it unchanged.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH. Push and pop in the same cycle are legal, including when full (pop frees the slot before the push) and when empty-to-one.
- A push into a full FIFO cannot occur by construction. The bench asserts this.
- Arithmetic is performed by the pipeline, truncated to W. This block does not modify data.

## Timing
- Reset: all outputs 0 (rN_ready, dp_*, oN_valid, oN_data, busy). Tags invalid, FIFOs empty, counters 0, pointer favours r0 first.
- Reset mid-operation: in-flight tags and FIFO contents are discarded. No response is produced for them after release.
- Latency: transfer at edge t gives dp_* valid during cycle t→t+1, the result captured at edge t+1+LAT, and oN_valid high after edge t+1+LAT. Total LAT+1 edges; 3 for LAT=2.
- Throughput: one issue per cycle sustained while credits allow.
- Back-to-back responses for the same requester appear on consecutive cycles, in issue order. Per-requester order is preserved.
- oN_valid/oN_data are registered (FIFO head). A pop at edge t presents the next entry after t.

## Configuration
- PIPE_ARB_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority. r0 wins whenever eligible, r1 is granted only when r0 is not eligible, and the pointer logic is removed.
- Undefined (default): round-robin as above.

## Test plan
- Single op, LAT=2: r0 a1=0,a2=2,b1=1,b2=3 transferred at edge 10 → o0_valid after edge 13, o0_data=6; o1_valid stays 0.
- Contention: both valid continuously, r0 {3,1,2,0} and r1 {1,1,1,1}, o*_ready=1 → grants alternate r0,r1,r0… starting with r0; o0_data=6 stream and o1_data=2 stream, no gaps once filled.
- Credit stall: r0 valid continuously, o0_ready=0, DEPTH=4 → exactly 4 transfers, then r0_ready=0. Raising o0_ready for one cycle → exactly one further transfer.
- FIFO wrap and simultaneous push/pop: 10 ops to r0 with o0_ready toggling every cycle → all 10 results in issue order, no loss or duplicate.
- Reset mid-flight: assert rst_n=0 one cycle after a transfer → all outputs 0 immediately; after release no stale o0_valid, busy=0.
- With PIPE_ARB_FIXED_PRIO_EN: both valid continuously, o*_ready=1 → r1_ready never asserted while r0 is eligible.
